shadow_register_file: RTL and testbench
=======================================

SHADOW_REGISTER_FILE -- requirements
Module: shadow_register_file

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of every register and data port.
REQ-002 Parameter DEPTH, default 6, SHALL set the register count (legal range 4..16); AW = max(1, clog2(DEPTH)) SHALL be the selector width.
REQ-003 clock  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 save  input  1  SHALL be the write request: write savebus to register saveselector.
REQ-006 saveselector  input  AW  SHALL be the write register index.
REQ-007 savebus  input  WIDTH  SHALL be the write data.
REQ-008 loadselector  input  AW  SHALL be the read register index.
REQ-009 loadbus  output  WIDTH  SHALL be the combinational read data.
REQ-010 jumptarget / aluoperandA / aluoperandB / aluresult  output  WIDTH each  SHALL be continuous taps of registers 0 / 1 / 2 / 3.
REQ-011 ctx_save_req  input  1  SHALL be the request to copy all registers into the shadow bank.
REQ-012 ctx_restore_req  input  1  SHALL be the request to copy the shadow bank back into the registers.
REQ-013 ctx_busy  output  1  SHALL be high while a save or restore sequence runs.
REQ-014 ctx_done  output  1  SHALL be a one-cycle pulse marking sequence completion.
REQ-015 stall  output  1  SHALL be high when save is asserted and the write is refused.

Function
REQ-016 Write accepted iff save=1, ctx_busy=0 and saveselector<DEPTH; the register updates on that rising edge.
REQ-017 Writes with saveselector>=DEPTH SHALL be ignored without stall.
REQ-018 stall SHALL equal save AND ctx_busy, combinationally.
REQ-019 loadbus SHALL equal register[loadselector], or 0 if loadselector>=DEPTH.
REQ-020 Taps SHALL reflect register contents with zero latency, including during save/restore sequences.
REQ-021 FSM states IDLE, SAVE, RESTORE; ctx_busy=1 exactly in SAVE and RESTORE.
REQ-022 In IDLE, ctx_save_req=1 SHALL enter SAVE with index counter 0; otherwise ctx_restore_req=1 SHALL enter RESTORE with index 0; simultaneous requests SHALL select SAVE.
REQ-023 Each SAVE cycle SHALL copy register[idx] to shadow[idx] and increment idx; each RESTORE cycle SHALL copy shadow[idx] to register[idx].
REQ-024 After the idx=DEPTH-1 copy the FSM SHALL return to IDLE; ctx_busy lasts exactly DEPTH cycles.
REQ-025 ctx_done SHALL be high only during the first IDLE cycle after a sequence.
REQ-026 ctx_save_req/ctx_restore_req while busy SHALL be ignored (not queued); a request held high in the ctx_done cycle SHALL start a new sequence immediately.
REQ-027 idx SHALL wrap to 0 on sequence end; no other wrap behaviour.

Reset
REQ-028 Reset SHALL clear all registers and shadow entries to 0, FSM to IDLE, idx to 0, ctx_done to 0, immediately and independent of clock.
REQ-029 Reset during SAVE or RESTORE SHALL abort the sequence; no ctx_done pulse follows.

Configuration
REQ-030 With macro SHADOW_REGISTER_FILE_BYPASS_EN defined, loadbus SHALL return savebus in the same cycle when a write is accepted and saveselector==loadselector; taps SHALL stay unbypassed.
REQ-031 Without SHADOW_REGISTER_FILE_BYPASS_EN, loadbus SHALL show the old value until the edge after the write.

Verification (WIDTH=8, DEPTH=6)
REQ-032 Reset, write 0x11..0x66 to regs 0..5 -> jumptarget=0x11, aluoperandA=0x22, aluoperandB=0x33, aluresult=0x44, loadselector=5 gives 0x66.
REQ-033 Pulse ctx_save_req, then overwrite all regs with 0x00 -> ctx_busy high 6 cycles, ctx_done one pulse; ctx_restore_req then restores 0x11..0x66 after 6 cycles.
REQ-034 save=1 during SAVE -> stall=1, target register unchanged; saveselector=7 in IDLE -> no change, stall=0.
REQ-035 ctx_save_req and ctx_restore_req together in IDLE -> SAVE runs, shadow = live registers, registers unchanged.
REQ-036 reset asserted at 3rd RESTORE cycle -> all registers and shadow 0, ctx_busy=0, no ctx_done.
REQ-037 save reg2=0xA5 with loadselector=2 -> loadbus=0xA5 same cycle with BYPASS_EN, old value without.

Source files
------------

// File: rtl/shadow_register_file_if.sv
// Bus bundle for shadow_register_file: write/read ports, register taps and
// the context save/restore handshake.
interface shadow_register_file_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             save;
  logic [AW-1:0]    saveselector;
  logic [WIDTH-1:0] savebus;
  logic [AW-1:0]    loadselector;
  logic [WIDTH-1:0] loadbus;
  logic [WIDTH-1:0] jumptarget;
  logic [WIDTH-1:0] aluoperandA;
  logic [WIDTH-1:0] aluoperandB;
  logic [WIDTH-1:0] aluresult;
  logic             ctx_save_req;
  logic             ctx_restore_req;
  logic             ctx_busy;
  logic             ctx_done;
  logic             stall;

  modport master (
    output save, saveselector, savebus, loadselector, ctx_save_req, ctx_restore_req,
    input  loadbus, jumptarget, aluoperandA, aluoperandB, aluresult,
           ctx_busy, ctx_done, stall
  );

  modport slave (
    input  save, saveselector, savebus, loadselector, ctx_save_req, ctx_restore_req,
    output loadbus, jumptarget, aluoperandA, aluoperandB, aluresult,
           ctx_busy, ctx_done, stall
  );
endinterface

// File: rtl/shadow_register_file.sv
// Register file with a shadow bank copied one entry per cycle on save/restore.
// Optional macro SHADOW_REGISTER_FILE_BYPASS_EN forwards an accepted write to loadbus.
module shadow_register_file_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             save_en_i,
  input  logic             restore_en_i,
  output logic [WIDTH-1:0] reg_o,
  output logic [WIDTH-1:0] shadow_o
);
  logic [WIDTH-1:0] reg_q, shadow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             reg_q <= '0;
    else if (restore_en_i) reg_q <= shadow_q;
    else if (wr_en_i)      reg_q <= wr_data_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          shadow_q <= '0;
    else if (save_en_i) shadow_q <= reg_q;
  end

  assign reg_o    = reg_q;
  assign shadow_o = shadow_q;
endmodule

module shadow_register_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  shadow_register_file_if.slave bus
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SAVE    = 2'd1;
  localparam logic [1:0] RESTORE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          busy, wr_acc;
  logic [WIDTH-1:0] rd_data;
  logic [DEPTH-1:0][WIDTH-1:0] regs, shadows;

  assign busy   = (state_q != IDLE);
  assign wr_acc = bus.save && !busy && ({1'b0, bus.saveselector} < DEPTH_W);

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    shadow_register_file_entry #(.WIDTH(WIDTH)) u_entry (
      .clock       (clock),
      .reset       (reset),
      .wr_en_i     (wr_acc && (bus.saveselector == AW'(g))),
      .wr_data_i   (bus.savebus),
      .save_en_i   ((state_q == SAVE) && (idx_q == AW'(g))),
      .restore_en_i((state_q == RESTORE) && (idx_q == AW'(g))),
      .reg_o       (regs[g]),
      .shadow_o    (shadows[g])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        // Save wins when both requests arrive together.
        if (bus.ctx_save_req)         state_d = SAVE;
        else if (bus.ctx_restore_req) state_d = RESTORE;
      end
      SAVE, RESTORE: begin
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.loadselector == AW'(i)) rd_data = regs[i];
`ifdef SHADOW_REGISTER_FILE_BYPASS_EN
    if (wr_acc && (bus.saveselector == bus.loadselector)) rd_data = bus.savebus;
`endif
  end

  assign bus.loadbus     = rd_data;
  assign bus.jumptarget  = regs[0];
  assign bus.aluoperandA = regs[1];
  assign bus.aluoperandB = regs[2];
  assign bus.aluresult   = regs[3];
  assign bus.ctx_busy    = busy;
  assign bus.ctx_done    = done_q;
  assign bus.stall       = bus.save && busy;

  // Shadow contents are only observable through a restore.
  logic unused_shadows;
  assign unused_shadows = ^shadows;
endmodule

// File: tb/tb_shadow_register_file.sv
// Directed + randomized bench for shadow_register_file (WIDTH=8, DEPTH=6)
// against a behavioural model of the register file and context sequences.
module tb_shadow_register_file;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_mis = 0;
  int   nbusy, ndone;

  shadow_register_file_if #(.WIDTH(8), .AW(3)) bus ();

  shadow_register_file #(.WIDTH(8), .DEPTH(6)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Reference model: mode 0 idle, 1 saving, 2 restoring; k = entry being copied next.
  int m_reg[6];
  int m_sh[6];
  int m_mode, m_k;
  bit m_done;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin m_reg[i] = 0; m_sh[i] = 0; end
    m_mode = 0; m_k = 0; m_done = 0;
  endtask

  task automatic check_outputs();
    int  ls, ss, exp_ld;
    bit  acc;
    ls  = int'(bus.loadselector);
    ss  = int'(bus.saveselector);
    acc = bus.save && (m_mode == 0) && (ss < 6);
    exp_ld = (ls < 6) ? m_reg[ls] : 0;
`ifdef SHADOW_REGISTER_FILE_BYPASS_EN
    if (acc && ss == ls) exp_ld = int'(bus.savebus);
`endif
    check("loadbus",     int'(bus.loadbus),     exp_ld);
    check("jumptarget",  int'(bus.jumptarget),  m_reg[0]);
    check("aluoperandA", int'(bus.aluoperandA), m_reg[1]);
    check("aluoperandB", int'(bus.aluoperandB), m_reg[2]);
    check("aluresult",   int'(bus.aluresult),   m_reg[3]);
    check("ctx_busy",    int'(bus.ctx_busy),    int'(m_mode != 0));
    check("ctx_done",    int'(bus.ctx_done),    int'(m_done));
    check("stall",       int'(bus.stall),       int'(bus.save && m_mode != 0));
  endtask

  task automatic model_edge();
    int ss;
    bit acc;
    ss  = int'(bus.saveselector);
    acc = bus.save && (m_mode == 0) && (ss < 6);
    if (m_mode == 1)      m_sh[m_k]  = m_reg[m_k];
    else if (m_mode == 2) m_reg[m_k] = m_sh[m_k];
    if (m_mode != 0) begin
      m_k++;
      m_done = 0;
      if (m_k == 6) begin m_mode = 0; m_k = 0; m_done = 1; end
    end else begin
      m_done = 0;
      if (bus.ctx_save_req)         begin m_mode = 1; m_k = 0; end
      else if (bus.ctx_restore_req) begin m_mode = 2; m_k = 0; end
    end
    if (acc) m_reg[ss] = int'(bus.savebus);
  endtask

  // Inputs are set just after a rising edge; outputs are checked 1ns later.
  task automatic tick();
    #1;
    check_outputs();
    if (bus.ctx_busy) nbusy++;
    if (bus.ctx_done) ndone++;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.save = 0; bus.saveselector = '0; bus.savebus = '0;
    bus.ctx_save_req = 0; bus.ctx_restore_req = 0;
  endtask

  task automatic write(input int sel, input int data);
    bus.save = 1; bus.saveselector = 3'(sel); bus.savebus = 8'(data);
    tick();
    bus.save = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    bus.loadselector = '0;
    model_reset();
    #2;
    do_reset();

    // Fill registers 0..5 with 0x11..0x66 and read the last one back.
    for (int i = 0; i < 6; i++) write(i, (i + 1) * 8'h11);
    bus.loadselector = 3'd5;
    tick();
    check("ld_reg5", int'(bus.loadbus), 8'h66);

    // Save, then clear everything, then restore.
    nbusy = 0; ndone = 0;
    bus.ctx_save_req = 1; tick(); bus.ctx_save_req = 0;
    for (int i = 0; i < 7; i++) tick();
    check("save_busy_cycles", nbusy, 6);
    check("save_done_pulses", ndone, 1);
    for (int i = 0; i < 6; i++) write(i, 0);
    check("cleared_tap", int'(bus.aluresult), 0);
    bus.ctx_restore_req = 1; tick(); bus.ctx_restore_req = 0;
    for (int i = 0; i < 7; i++) tick();
    check("restored_jt", int'(bus.jumptarget), 8'h11);
    check("restored_r3", int'(bus.aluresult), 8'h44);

    // Writes during SAVE stall; out-of-range write in IDLE is silently dropped.
    bus.ctx_save_req = 1; tick(); bus.ctx_save_req = 0;
    for (int i = 0; i < 6; i++) begin
      bus.save = 1; bus.saveselector = 3'd2; bus.savebus = 8'($urandom);
      tick();
    end
    bus.save = 0;
    tick();
    check("stalled_r2", int'(bus.aluoperandB), 8'h33);
    bus.save = 1; bus.saveselector = 3'd7; bus.savebus = 8'hEE; bus.loadselector = 3'd7;
    tick();
    bus.save = 0;

    // Simultaneous requests pick SAVE; registers must not change.
    bus.ctx_save_req = 1; bus.ctx_restore_req = 1; tick();
    bus.ctx_save_req = 0; bus.ctx_restore_req = 0;
    for (int i = 0; i < 7; i++) tick();
    check("simul_r1", int'(bus.aluoperandA), 8'h22);

    // Randomized traffic, including requests while busy and in the done cycle.
    for (int c = 0; c < 300; c++) begin
      bus.save            = 1'($urandom);
      bus.saveselector    = 3'($urandom);
      bus.savebus         = 8'($urandom);
      bus.loadselector    = 3'($urandom);
      bus.ctx_save_req    = ($urandom_range(0, 11) == 0);
      bus.ctx_restore_req = ($urandom_range(0, 11) == 0);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) tick();

    // Reset in the 3rd RESTORE cycle: everything zero, no done pulse afterwards.
    for (int i = 0; i < 6; i++) write(i, 8'h80 + i);
    bus.ctx_save_req = 1; tick(); bus.ctx_save_req = 0;
    for (int i = 0; i < 7; i++) tick();
    bus.ctx_restore_req = 1; tick(); bus.ctx_restore_req = 0;
    tick(); tick();
    #2;
    do_reset();
    check("abort_busy", int'(bus.ctx_busy), 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_done", ndone, 0);
    for (int i = 0; i < 6; i++) write(i, 8'h5A);
    bus.ctx_restore_req = 1; tick(); bus.ctx_restore_req = 0;
    for (int i = 0; i < 7; i++) tick();
    check("shadow_cleared", int'(bus.aluresult), 0);

    // Same-cycle read of a register being written.
    write(2, 8'h3C);
    bus.save = 1; bus.saveselector = 3'd2; bus.savebus = 8'hA5; bus.loadselector = 3'd2;
    #1;
`ifdef SHADOW_REGISTER_FILE_BYPASS_EN
    check("bypass_ld", int'(bus.loadbus), 8'hA5);
`else
    check("bypass_ld", int'(bus.loadbus), 8'h3C);
`endif
    tick();
    bus.save = 0;
    tick();
    check("after_write_ld", int'(bus.loadbus), 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
